// File: rtl/dreg_deser_pkg.sv
// Shared definitions for the dreg_deser serial-to-parallel deserializer.
package dreg_deser_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

endpackage

// File: rtl/dreg_deser.sv
// Deserializer: hunts for a start bit, assembles WIDTH bits LSB-first, optionally checks even
// parity, and presents the word on a valid/ready slot with parity-error and overrun status.
module dreg_deser
    import dreg_deser_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          PARITY_EN = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             bit_reg,
    input  logic             bit_en,
    input  logic             word_ready,
    input  logic             clear_err,
    output logic [WIDTH-1:0] word_reg,
    output logic             word_valid_reg,
    output logic             parity_err_reg,
    output logic             overrun_reg,
    output logic             busy_reg
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] shift_q;

    logic [WIDTH-1:0] shift_next;
    logic             last_data;
    logic             slot_free;
    logic             deliver;
    logic [WIDTH-1:0] deliver_word;
    logic             deliver_err;

    assign shift_next = {bit_reg, shift_q[WIDTH-1:1]};
    assign last_data  = (cnt_q == CW'(WIDTH - 1));
    assign slot_free  = !word_valid_reg || word_ready;

    always_comb begin
        deliver      = 1'b0;
        deliver_word = shift_next;
        deliver_err  = 1'b0;
        if (bit_en) begin
            case (state_q)
                DATA: deliver = last_data && !PARITY_EN;
                PAR: begin
                    deliver      = 1'b1;
                    deliver_word = shift_q;
                    deliver_err  = (^shift_q) ^ bit_reg;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            shift_q        <= '0;
            word_reg       <= '0;
            word_valid_reg <= 1'b0;
            parity_err_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            if (bit_en) begin
                case (state_q)
                    IDLE: begin
                        if (bit_reg) begin
                            state_q  <= DATA;
                            cnt_q    <= '0;
                            busy_reg <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift_q <= shift_next;
                        cnt_q   <= cnt_q + CW'(1);
                        if (last_data) begin
                            state_q  <= PARITY_EN ? PAR : IDLE;
                            busy_reg <= PARITY_EN;
                        end
                    end
                    PAR: begin
                        state_q  <= IDLE;
                        busy_reg <= 1'b0;
                    end
                    default: begin
                        state_q  <= IDLE;
                        busy_reg <= 1'b0;
                    end
                endcase
            end

            // A load on the accept edge keeps valid high with the new word.
            if (deliver && slot_free) begin
                word_reg       <= deliver_word;
                parity_err_reg <= deliver_err;
                word_valid_reg <= 1'b1;
            end else if (word_valid_reg && word_ready) begin
                word_valid_reg <= 1'b0;
            end

            if (deliver && !slot_free) begin
                overrun_reg <= 1'b1;
            end else if (clear_err) begin
                overrun_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dreg_deser.sv
// Directed self-checking bench for dreg_deser, with parity (dut_a) and without (dut_b).
module tb_dreg_deser;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       bit_reg, bit_en, word_ready, clear_err;
    logic [7:0] word_reg;
    logic       word_valid_reg, parity_err_reg, overrun_reg, busy_reg;

    logic       bit_reg_b, bit_en_b;
    logic [7:0] word_reg_b;
    logic       word_valid_reg_b, parity_err_reg_b, overrun_reg_b, busy_reg_b;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    dreg_deser #(.WIDTH(8), .PARITY_EN(1'b1)) dut_a (
        .clock          (clock),
        .reset_n        (reset_n),
        .bit_reg        (bit_reg),
        .bit_en         (bit_en),
        .word_ready     (word_ready),
        .clear_err      (clear_err),
        .word_reg       (word_reg),
        .word_valid_reg (word_valid_reg),
        .parity_err_reg (parity_err_reg),
        .overrun_reg    (overrun_reg),
        .busy_reg       (busy_reg)
    );

    dreg_deser #(.WIDTH(8), .PARITY_EN(1'b0)) dut_b (
        .clock          (clock),
        .reset_n        (reset_n),
        .bit_reg        (bit_reg_b),
        .bit_en         (bit_en_b),
        .word_ready     (1'b1),
        .clear_err      (1'b0),
        .word_reg       (word_reg_b),
        .word_valid_reg (word_valid_reg_b),
        .parity_err_reg (parity_err_reg_b),
        .overrun_reg    (overrun_reg_b),
        .busy_reg       (busy_reg_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_en  = 1'b1;
        bit_reg = b;
        tick();
        bit_en  = 1'b0;
        bit_reg = 1'b0;
    endtask

    // Start bit plus eight data bits, LSB first; parity bit is sent by the caller.
    task automatic send_data(input logic [7:0] w);
        send_bit(1'b1);
        for (int i = 0; i < 8; i++) send_bit(w[i]);
    endtask

    task automatic send_bit_b(input logic b);
        bit_en_b  = 1'b1;
        bit_reg_b = b;
        tick();
        bit_en_b  = 1'b0;
        bit_reg_b = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        bit_reg    = 1'b0;
        bit_en     = 1'b0;
        word_ready = 1'b1;
        clear_err  = 1'b0;
        bit_reg_b  = 1'b0;
        bit_en_b   = 1'b0;
        repeat (3) tick();

        chk("rst_word", word_reg, 0);
        chk("rst_valid", word_valid_reg, 0);
        chk("rst_perr", parity_err_reg, 0);
        chk("rst_ovr", overrun_reg, 0);
        chk("rst_busy", busy_reg, 0);
        reset_n = 1'b1;
        tick();

        // Idle-low line stays in IDLE.
        send_bit(1'b0);
        chk("idle_low_busy", busy_reg, 0);

        // 0xA5 with correct parity
        send_data(8'hA5);
        chk("a5_busy_pre_par", busy_reg, 1);
        chk("a5_valid_pre_par", word_valid_reg, 0);
        send_bit(1'b0);
        chk("a5_valid", word_valid_reg, 1);
        chk("a5_word", word_reg, 32'hA5);
        chk("a5_perr", parity_err_reg, 0);
        chk("a5_busy_done", busy_reg, 0);
        tick();
        chk("a5_valid_one_cycle", word_valid_reg, 0);

        // 0xA5 with wrong parity
        send_data(8'hA5);
        send_bit(1'b1);
        chk("a5bad_word", word_reg, 32'hA5);
        chk("a5bad_perr", parity_err_reg, 1);
        chk("a5bad_ovr", overrun_reg, 0);
        tick();

        // Backpressure and overrun
        word_ready = 1'b0;
        send_data(8'hA5);
        send_bit(1'b0);
        chk("bp_first_valid", word_valid_reg, 1);
        chk("bp_first_perr", parity_err_reg, 0);
        send_data(8'h3C);
        send_bit(1'b0);
        chk("bp_word_held", word_reg, 32'hA5);
        chk("bp_valid", word_valid_reg, 1);
        chk("bp_ovr", overrun_reg, 1);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        chk("bp_accept", word_valid_reg, 0);
        chk("bp_ovr_sticky", overrun_reg, 1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("bp_clear", overrun_reg, 0);

        // bit_en on every third cycle, inverted junk on gap cycles
        word_ready = 1'b1;
        begin
            logic [8:0] f;
            f = {8'h81, 1'b1};
            for (int i = 0; i < 9; i++) begin
                bit_reg = ~f[i];
                tick();
                tick();
                if (i > 0) chk("gap_busy", busy_reg, 1);
                send_bit(f[i]);
            end
            chk("gap_busy_par", busy_reg, 1);
            chk("gap_valid_pre", word_valid_reg, 0);
            bit_reg = 1'b1;
            tick();
            tick();
            send_bit(1'b0);
        end
        chk("gap_word", word_reg, 32'h81);
        chk("gap_valid", word_valid_reg, 1);
        chk("gap_busy_done", busy_reg, 0);
        tick();

        // Accept and load on the same edge
        word_ready = 1'b0;
        send_data(8'h11);
        send_bit(1'b0);
        chk("sim_first", word_reg, 32'h11);
        send_data(8'h22);
        word_ready = 1'b1;
        send_bit(1'b0);
        word_ready = 1'b0;
        chk("sim_valid", word_valid_reg, 1);
        chk("sim_word", word_reg, 32'h22);
        chk("sim_ovr", overrun_reg, 0);
        word_ready = 1'b1;
        tick();

        // Reset mid-frame: asynchronous, before any clock edge
        send_bit(1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        chk("mid_busy", busy_reg, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_word", word_reg, 0);
        chk("mid_rst_busy", busy_reg, 0);
        chk("mid_rst_valid", word_valid_reg, 0);
        tick();
        reset_n = 1'b1;
        tick();
        send_data(8'h5A);
        send_bit(1'b0);
        chk("post_rst_word", word_reg, 32'h5A);
        chk("post_rst_valid", word_valid_reg, 1);
        chk("post_rst_perr", parity_err_reg, 0);
        tick();

        // No-parity instance: delivers on the eighth data bit
        chk("b_reset_word", word_reg_b, 0);
        send_bit_b(1'b1);
        for (int i = 0; i < 7; i++) send_bit_b(i[0] ? 1'b1 : 1'b0);
        chk("b_busy", busy_reg_b, 1);
        chk("b_valid_pre", word_valid_reg_b, 0);
        send_bit_b(1'b1);
        chk("b_valid", word_valid_reg_b, 1);
        chk("b_word", word_reg_b, 32'hAA);
        chk("b_perr", parity_err_reg_b, 0);
        chk("b_busy_done", busy_reg_b, 0);
        // Back-to-back frame with no dead cycle
        send_bit_b(1'b1);
        chk("b_b2b_busy", busy_reg_b, 1);
        chk("b_accepted", word_valid_reg_b, 0);
        for (int i = 0; i < 8; i++) send_bit_b(i < 4 ? 1'b1 : 1'b0);
        chk("b2_word", word_reg_b, 32'h0F);
        chk("b2_valid", word_valid_reg_b, 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
